// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, WIDTH cycles each.
// Optional MULDIV_EARLY_OUT_EN: special-case operations complete in one cycle.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 a_sgn, b_sgn, a_neg, b_neg, sign_in;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next;
    logic [WIDTH-1:0]     prod_hi, prod_lo, mul_hi, fix_val;

    // Divide-by-zero, signed overflow and zero-operand multiply.
    function automatic logic is_special(input logic dv, input logic uns,
                                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (dv) return (b == '0) || (!uns && a == MinNeg && b == AllOnes);
        return (a == '0) || (b == '0);
    endfunction

    function automatic logic [WIDTH-1:0] special_val(input logic dv, input logic rm,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        if (!dv) return '0;
        if (b == '0) return rm ? a : AllOnes;
        return rm ? '0 : a;
    endfunction

    always_comb begin
        a_sgn = (funct3 == OpMulh) || (funct3 == OpMulhsu) || (funct3 == OpDiv) || (funct3 == OpRem);
        b_sgn = (funct3 == OpMulh) || (funct3 == OpDiv) || (funct3 == OpRem);
        a_neg = a_sgn & srcA[WIDTH-1];
        b_neg = b_sgn & srcB[WIDTH-1];
        a_mag = a_neg ? -srcA : srcA;
        b_mag = b_neg ? -srcB : srcB;
        case (funct3)
            OpMulh, OpMulhsu, OpDiv: sign_in = a_neg ^ b_neg;
            OpRem:                   sign_in = a_neg;
            default:                 sign_in = 1'b0;
        endcase
    end

    // prod_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_hi = prod_q[2*WIDTH-1:WIDTH];
        prod_lo = prod_q[WIDTH-1:0];
        mul_hi  = neg_q ? (~prod_hi + WIDTH'(prod_lo == '0)) : prod_hi;
        case (op_q)
            OpMul:                     fix_val = prod_lo;
            OpMulh, OpMulhsu, OpMulhu: fix_val = mul_hi;
            OpDiv, OpDivu:             fix_val = neg_q ? -prod_lo : prod_lo;
            default:                   fix_val = neg_q ? -prod_hi : prod_hi;
        endcase
        if (is_special(op_q[2], op_q[0], a_raw_q, b_raw_q)) begin
            fix_val = special_val(op_q[2], op_q[1], a_raw_q, b_raw_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_raw_d  = a_raw_q;
        b_raw_d  = b_raw_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        op_d    = funct3;
                        a_raw_d = srcA;
                        b_raw_d = srcB;
                        neg_d   = sign_in;
                        cnt_d   = '0;
                        mcand_d = funct3[2] ? b_mag : a_mag;
                        prod_d  = {{WIDTH{1'b0}}, funct3[2] ? a_mag : b_mag};
                        state_d = StCalc;
`ifdef MULDIV_EARLY_OUT_EN
                        if (is_special(funct3[2], funct3[0], srcA, srcB)) begin
                            result_d = special_val(funct3[2], funct3[1], srcA, srcB);
                            state_d  = StDone;
                        end
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
                StCalc: begin
                    prod_d = op_q[2] ? div_next : mul_next;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LastIter) state_d = StFix;
                end
                StFix: begin
                    result_d = fix_val;
                    state_d  = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_raw_q  <= '0;
            b_raw_q  <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_raw_q  <= a_raw_d;
            b_raw_q  <= b_raw_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StCalc) || (state_q == StFix);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed table-driven bench for mul_div_unit (WIDTH=32), plus reset/flush/back-to-back sequences.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   funct3;
    logic [W-1:0] srcA, srcB;
    logic         busy, done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           spec;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the start edge.
    task automatic launch(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        funct3 = f;
        srcA   = a;
        srcB   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, exp_lat, ndone;
        vecs[0]  = '{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,        1'b0};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,         1'b0};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,         1'b1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1};
        vecs[12] = '{3'b000, 32'd0,        32'd12345,    32'd0,         1'b1};
        vecs[13] = '{3'b001, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1'b0};
        vecs[14] = '{3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        vecs[15] = '{3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         1'b0};
        vecs[16] = '{3'b100, 32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFFF, 1'b1};
        vecs[17] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1,         1'b0};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; srcA = '0; srcB = '0;
        #2;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
`ifdef MULDIV_EARLY_OUT_EN
            exp_lat = vecs[i].spec ? 0 : W + 1;
`else
            exp_lat = W + 1;
`endif
            launch(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            check($sformatf("vec%0d result", i), result, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'(exp_lat));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done single pulse", i), 32'(done), 32'd0);
        end

        // Asynchronous reset at CALC iteration 10.
        launch(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midcalc rst busy", 32'(busy), 32'd0);
        check("midcalc rst done", 32'(done), 32'd0);
        check("midcalc rst result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        launch(3'b101, 32'd100, 32'd7);
        wait_done(lat, bcnt);
        check("post-rst result", result, 32'd14);
        check("post-rst latency", 32'(lat), 32'(W + 1));

        // Flush at iteration 5: no done, result keeps 14.
        @(posedge clk);
        #1;
        launch(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        ndone = 0;
        for (int k = 0; k < 2 * W; k++) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        check("flush no done", 32'(ndone), 32'd0);
        check("flush result kept", result, 32'd14);

        // start held high across the busy period with new operands, then accepted in done cycle.
        funct3 = 3'b000; srcA = 32'd7; srcB = 32'hFFFF_FFFD; start = 1'b1;
        @(posedge clk);
        #1;
        funct3 = 3'b111; srcA = 32'd100; srcB = 32'd7;
        wait_done(lat, bcnt);
        check("b2b first result", result, 32'hFFFF_FFEB);
        check("b2b first latency", 32'(lat), 32'(W + 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b no gap busy", 32'(busy), 32'd1);
        check("b2b no gap done", 32'(done), 32'd0);
        wait_done(lat, bcnt);
        check("b2b second result", result, 32'd2);
        check("b2b second latency", 32'(lat), 32'(W + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
